// File: rtl/dc_hex_ascii.sv
// rtl/dc_hex_ascii.sv - registered 4-bit hex nibble to ASCII converter
// Optional X/Z input detection is enabled with DC_HEX_ASCII_XCHECK_EN.
module dc_hex_ascii #(
  parameter bit LOWER_CASE = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] hex_i,
  input  logic       hex_valid_i,
  output logic [7:0] ascii_o,
  output logic       ascii_valid_o,
  output logic       err_o
);

  localparam logic [7:0] LetterBase = LOWER_CASE ? 8'h61 : 8'h41;

  logic [7:0] ascii_map;
  logic [7:0] ascii_d, ascii_q;
  logic       valid_d, valid_q;

  always_comb begin
    ascii_map = 8'h00;
    if (hex_i < 4'hA) begin
      ascii_map = 8'h30 + {4'h0, hex_i};
    end else begin
      ascii_map = LetterBase + ({4'h0, hex_i} - 8'd10);
    end
  end

`ifdef DC_HEX_ASCII_XCHECK_EN
  logic err_d, err_q;

  // Any unknown bit in an accepted nibble yields '?' and raises the error flag.
  always_comb begin
    ascii_d = ascii_q;
    err_d   = err_q;
    valid_d = hex_valid_i;
    if (hex_valid_i) begin
      if ($isunknown(hex_i)) begin
        ascii_d = 8'h3F;
        err_d   = 1'b1;
      end else begin
        ascii_d = ascii_map;
        err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  always_comb begin
    ascii_d = ascii_q;
    valid_d = hex_valid_i;
    if (hex_valid_i) begin
      ascii_d = ascii_map;
    end
  end

  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ascii_q <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      ascii_q <= ascii_d;
      valid_q <= valid_d;
    end
  end

  assign ascii_o       = ascii_q;
  assign ascii_valid_o = valid_q;

endmodule

// File: tb/tb_dc_hex_ascii.sv
// tb/tb_dc_hex_ascii.sv - scoreboard bench for dc_hex_ascii, upper and lower case instances
// The X/Z input scenario is compiled only with DC_HEX_ASCII_XCHECK_EN.
module tb_dc_hex_ascii;

  logic       clk;
  logic       rst_n;
  logic [3:0] hex;
  logic       hex_valid;
  logic [7:0] ascii_u, ascii_l;
  logic       valid_u, valid_l;
  logic       err_u, err_l;

  int checks = 0;
  int errors = 0;
  int run_len = 0;
  int last_run = 0;

  logic [8:0] q_u[$];
  logic [8:0] q_l[$];

  dc_hex_ascii #(.LOWER_CASE(1'b0)) u_upper (
    .clk_i(clk), .rst_ni(rst_n), .hex_i(hex), .hex_valid_i(hex_valid),
    .ascii_o(ascii_u), .ascii_valid_o(valid_u), .err_o(err_u)
  );

  dc_hex_ascii #(.LOWER_CASE(1'b1)) u_lower (
    .clk_i(clk), .rst_ni(rst_n), .hex_i(hex), .hex_valid_i(hex_valid),
    .ascii_o(ascii_l), .ascii_valid_o(valid_l), .err_o(err_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares {err, ascii} whenever a result is presented.
  always @(negedge clk) begin
    if (valid_u) begin
      run_len++;
      if (q_u.size() == 0) check("upper_spurious_valid", {err_u, ascii_u}, 9'h1FF);
      else check("upper_result", {err_u, ascii_u}, q_u.pop_front());
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
    if (valid_l) begin
      if (q_l.size() == 0) check("lower_spurious_valid", {err_l, ascii_l}, 9'h1FF);
      else check("lower_result", {err_l, ascii_l}, q_l.pop_front());
    end
  end

  task automatic send(input logic [3:0] h, input logic [7:0] eu, input logic [7:0] el);
    hex = h;
    hex_valid = 1'b1;
    q_u.push_back({1'b0, eu});
    q_l.push_back({1'b0, el});
    @(posedge clk); #1;
  endtask

  task automatic idle();
    hex_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [7:0] exp_u [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                             8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
  logic [7:0] exp_l [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                             8'h38, 8'h39, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    hex = 4'hF;
    hex_valid = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check("reset_ascii_u", {1'b0, ascii_u}, 9'h000);
      check("reset_ascii_l", {1'b0, ascii_l}, 9'h000);
      check("reset_valid_err", {7'd0, valid_u, err_u}, 9'h000);
    end
    rst_n = 1'b1;
    hex_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) send(i[3:0], exp_u[i], exp_l[i]);
    idle();
    idle();
    check("sweep_valid_run", last_run[8:0], 9'd16);

    send(4'h7, 8'h37, 8'h37);
    hex = 4'h2;
    hex_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("hold_ascii", {1'b0, ascii_u}, 9'h037);
      check("hold_valid", {8'd0, valid_u}, 9'h000);
    end

    send(4'hA, 8'h41, 8'h61);
    send(4'hF, 8'h46, 8'h66);
    idle();

`ifdef DC_HEX_ASCII_XCHECK_EN
    hex = 4'bxxxx; hex_valid = 1'b1;
    q_u.push_back(9'h13F); q_l.push_back(9'h13F);
    @(posedge clk); #1;
    hex = 4'bzzzz;
    q_u.push_back(9'h13F); q_l.push_back(9'h13F);
    @(posedge clk); #1;
    send(4'h0, 8'h30, 8'h30);
    idle();
`endif

    send(4'hF, 8'h46, 8'h66);
    hex_valid = 1'b0;
    @(negedge clk); #1;
    check("async_pre_ascii", {1'b0, ascii_u}, 9'h046);
    rst_n = 1'b0;
    #1;
    check("async_ascii_u", {1'b0, ascii_u}, 9'h000);
    check("async_ascii_l", {1'b0, ascii_l}, 9'h000);
    check("async_valid_err", {6'd0, valid_u, valid_l, err_u}, 9'h000);
    #1;
    rst_n = 1'b1;
    idle();
    check("post_reset_ascii", {1'b0, ascii_u}, 9'h000);

    send(4'h9, 8'h39, 8'h39);
    idle();
    idle();
    check("queue_u_drained", q_u.size(), 9'd0);
    check("queue_l_drained", q_l.size(), 9'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dc_hex_ascii.md
DC_HEX_ASCII -- requirements
Module: dc_hex_ascii

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter LOWER_CASE, default 0: 0 SHALL select letters 'A'-'F'; 1 SHALL select 'a'-'f'.
REQ-003 CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 RST_N, input, 1 bit: asynchronous active-low reset.
REQ-005 HEX, input, 4 bits: the nibble to convert.
REQ-006 HEX_VALID, input, 1 bit: HEX SHALL be sampled when this is 1 at a rising CLK.
REQ-007 ASCII, output, 8 bits: registered ASCII code of the last accepted nibble.
REQ-008 ASCII_VALID, output, 1 bit: SHALL pulse high for one cycle per accepted nibble.
REQ-009 ERR, output, 1 bit: registered unknown-input flag; see Configuration.

Function
REQ-010 HEX 0x0-0x9 SHALL map to 8'h30-8'h39 ('0'-'9').
REQ-011 HEX 0xA-0xF SHALL map to 8'h41-8'h46 when LOWER_CASE=0, and to 8'h61-8'h66 when LOWER_CASE=1.
REQ-012 Latency SHALL be exactly 1 cycle: the edge that samples HEX_VALID=1 updates ASCII and sets ASCII_VALID=1.
REQ-013 At an edge with HEX_VALID=0, ASCII SHALL hold its value, ASCII_VALID SHALL be 0, and ERR SHALL hold.
REQ-014 Back-to-back HEX_VALID=1 cycles SHALL each produce a new result with no bubbles; ASCII_VALID SHALL stay high continuously.
REQ-015 There is no backpressure; results not consumed in their valid cycle SHALL be overwritten by the next accepted nibble.
REQ-016 The mapping SHALL be purely combinational ahead of a single register stage, with no other state.

Reset
REQ-017 While RST_N=0, ASCII SHALL be 8'h00, ASCII_VALID SHALL be 0 and ERR SHALL be 0, independent of CLK.
REQ-018 Reset asserted mid-stream SHALL clear the outputs immediately, and any in-flight nibble SHALL be discarded.
REQ-019 After RST_N rises, the first accepted nibble SHALL appear one cycle after it is sampled.

Configuration
REQ-020 Macro DC_HEX_ASCII_XCHECK_EN, when defined: if any HEX bit is X or Z at an accepting edge, ASCII SHALL load 8'h3F ('?') and ERR SHALL load 1.
REQ-021 With DC_HEX_ASCII_XCHECK_EN defined, a valid nibble SHALL load ERR=0.
REQ-022 Without DC_HEX_ASCII_XCHECK_EN, ERR SHALL be tied to 0 and no X/Z detection logic SHALL exist; unknown inputs propagate per simulator semantics.

Verification
REQ-023 Reset: RST_N=0 with HEX=4'hF, HEX_VALID=1 -> ASCII=8'h00, ASCII_VALID=0, ERR=0 throughout.
REQ-024 Sweep: HEX 0x0..0xF with HEX_VALID=1 on consecutive cycles, LOWER_CASE=0 -> ASCII 30..39 then 41..46, each one cycle later, ASCII_VALID high for 16 cycles.
REQ-025 Lower case: LOWER_CASE=1, HEX=4'hA then 4'hF -> ASCII 8'h61 then 8'h66.
REQ-026 Hold: HEX=4'h7 accepted, then HEX_VALID=0 while HEX=4'h2 -> ASCII stays 8'h37 and ASCII_VALID=0.
REQ-027 Unknown input with DC_HEX_ASCII_XCHECK_EN: HEX=4'bxxxx, then 4'bzzzz, with HEX_VALID=1 -> ASCII=8'h3F and ERR=1; a following HEX=4'h0 -> ASCII=8'h30 and ERR=0.
REQ-028 Async reset: RST_N pulsed low between edges while ASCII=8'h46 -> ASCII=8'h00 immediately, before the next CLK edge.
